life_step_engine: RTL

LIFE_STEP_ENGINE -- requirements
Module: life_step_engine

---
 rtl/life_step_engine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/life_step_engine.sv
// Game-of-Life stepper for an 8x8 board of 2-bit cells. One cell is evaluated
// per cycle into a shadow buffer, and the whole shadow is committed at once.
module life_step_engine #(
    parameter int WRAP = 1,
    parameter int FADE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init_load,
    input  logic [127:0] initial_pattern,
    input  logic         step,
    output logic         busy,
    output logic         done,
    output logic [127:0] grid,
    output logic [15:0]  generation
);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    state_t       state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [127:0] grid_q, grid_d;
    logic [127:0] shadow_q, shadow_d;
    logic [15:0]  gen_q, gen_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [3:0]   live_cnt;
    logic [1:0]   cur, nxt;
    int           r, c;

    // Neighbours are always read from the committed grid, never from shadow.
    always_comb begin
        live_cnt = '0;
        r = 0;
        c = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = int'(idx_q[5:3]) + dr;
                c = int'(idx_q[2:0]) + dc;
                if (WRAP != 0) begin
                    r = r & 7;
                    c = c & 7;
                end
                if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8) begin
                    if (grid_q[2*(r*8+c) +: 2] == 2'b11) live_cnt = live_cnt + 4'd1;
                end
            end
        end
    end

    always_comb begin
        cur = grid_q[{idx_q, 1'b0} +: 2];
        nxt = 2'b00;
        if (live_cnt == 4'd3) begin
            nxt = 2'b11;
        end else begin
            case (cur)
                2'b11:   nxt = (live_cnt == 4'd2) ? 2'b11 : ((FADE != 0) ? 2'b01 : 2'b00);
                2'b01:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        grid_d   = grid_q;
        shadow_d = shadow_q;
        gen_d    = gen_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (step) begin
                    state_d = CALC;
                    idx_d   = '0;
                end
            end
            CALC: begin
                shadow_d[{idx_q, 1'b0} +: 2] = nxt;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) state_d = COMMIT;
            end
            COMMIT: begin
                grid_d  = shadow_q;
                done_d  = 1'b1;
                gen_d   = gen_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A load wins over everything, including a step on the same edge.
        if (init_load) begin
            grid_d  = initial_pattern;
            gen_d   = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            state_d = IDLE;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            grid_q   <= '0;
            shadow_q <= '0;
            gen_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            grid_q   <= grid_d;
            shadow_q <= shadow_d;
            gen_q    <= gen_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign grid       = grid_q;
    assign generation = gen_q;

endmodule
